// File: rtl/conv_output_writer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_output_writer
//  Purpose  : Buffers the accelerator result stream in a small FIFO and writes
//             each result to memory at a linear (y, x, ch) address.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_output_writer #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int ADDR_WIDTH         = 18,
  parameter int CNT_WIDTH          = 18
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  start,
  input  logic [CNT_WIDTH-1:0]                  expected_count,
  input  logic [IO_DATA_WIDTH-1:0]              out,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [IO_DATA_WIDTH-1:0]              mem_wdata,
  output logic                                  mem_we,
  input  logic                                  mem_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] exp_q, exp_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [IO_DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] addr_w;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  fifo_empty, fifo_full, pop, push;

  // Arithmetic is carried out at ADDR_WIDTH so the result wraps naturally.
  assign addr_w = (ADDR_WIDTH'(output_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH)
                   + ADDR_WIDTH'(output_x)) * ADDR_WIDTH'(OUTPUT_NB_CHANNELS)
                  + ADDR_WIDTH'(output_ch);

  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign pop        = mem_we && mem_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    if (start) begin
      // Start always wins: flush, clear and (re)enter RUN from any state.
      state_d  = ST_RUN;
      exp_d    = expected_count;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case (state_q)
        ST_RUN: begin
          if (output_valid) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            // A same-cycle pop frees the slot, so a full FIFO still accepts.
            if (!fifo_full || pop) begin
              push     = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if ((exp_q == '0) || (cnt_d == exp_q)) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wr_ptr_q == rd_ptr_d) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      exp_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_idx] <= out;
      addr_mem_q[wr_idx] <= addr_w;
    end
  end

  assign mem_we    = !fifo_empty;
  assign mem_addr  = mem_we ? addr_mem_q[rd_idx] : '0;
  assign mem_wdata = mem_we ? data_mem_q[rd_idx] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_output_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_output_writer
//  Purpose  : Directed, table-driven self-checking bench for conv_output_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [17:0] expected_count;
  logic [15:0] out;
  logic        output_valid;
  logic [6:0]  output_x;
  logic [6:0]  output_y;
  logic [3:0]  output_ch;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic [3:0]  ch;
    logic [15:0] data;
    logic [17:0] addr;
  } vec_t;

  vec_t tbl [6];

  conv_output_writer dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .start          (start),
    .expected_count (expected_count),
    .out            (out),
    .output_valid   (output_valid),
    .output_x       (output_x),
    .output_y       (output_y),
    .output_ch      (output_ch),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    output_valid = 1'b1;
    output_x     = tbl[i].x;
    output_y     = tbl[i].y;
    output_ch    = tbl[i].ch;
    out          = tbl[i].data;
  endtask

  task automatic begin_layer(input logic [17:0] cnt);
    expected_count = cnt;
    start          = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_head(input string name, input int i);
    check({name, " we"},   32'(mem_we), 32'd1);
    check({name, " addr"}, 32'(mem_addr), 32'(tbl[i].addr));
    check({name, " data"}, 32'(mem_wdata), 32'(tbl[i].data));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " we"},       32'(mem_we), 32'd0);
    check({name, " addr"},     32'(mem_addr), 32'd0);
    check({name, " wdata"},    32'(mem_wdata), 32'd0);
    check({name, " busy"},     32'(busy), 32'd0);
    check({name, " done"},     32'(done), 32'd0);
    check({name, " overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    // x, y, ch, data, hand-computed (y*128+x)*16+ch
    tbl[0] = '{7'd0,   7'd0,   4'd0,  16'h0011, 18'd0};
    tbl[1] = '{7'd0,   7'd0,   4'd1,  16'h0012, 18'd1};
    tbl[2] = '{7'd1,   7'd0,   4'd0,  16'h0013, 18'd16};
    tbl[3] = '{7'd127, 7'd127, 4'd15, 16'h0014, 18'd262143};
    tbl[4] = '{7'd5,   7'd2,   4'd3,  16'h0015, 18'd4179};
    tbl[5] = '{7'd127, 7'd0,   4'd15, 16'h0016, 18'd2047};

    arst_n_in      = 1'b0;
    start          = 1'b0;
    expected_count = '0;
    out            = '0;
    output_valid   = 1'b0;
    output_x       = '0;
    output_y       = '0;
    output_ch      = '0;
    mem_ready      = 1'b1;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();

    // Valid pulses in IDLE are ignored
    for (int k = 0; k < 2; k++) begin
      drive(k);
      tick();
      check("idle valid we", 32'(mem_we), 32'd0);
      check("idle valid busy", 32'(busy), 32'd0);
    end
    output_valid = 1'b0;

    // Streaming without stall: each result visible one cycle after input
    mem_ready = 1'b1;
    begin_layer(18'd6);
    check("stream busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(i);
      tick();
      check_head($sformatf("stream[%0d]", i), i);
      check("stream done early", 32'(done), 32'd0);
    end
    output_valid = 1'b0;
    tick();
    check("stream done", 32'(done), 32'd1);
    check("stream busy end", 32'(busy), 32'd0);
    check("stream we end", 32'(mem_we), 32'd0);
    check("stream overflow", 32'(overflow), 32'd0);

    // Backpressure fill: 4 buffered, 5th dropped, then head stall and drain
    mem_ready = 1'b0;
    begin_layer(18'd5);
    for (int i = 0; i < 5; i++) begin
      drive(i);
      tick();
    end
    output_valid = 1'b0;
    check("bp overflow", 32'(overflow), 32'd1);
    check("bp busy", 32'(busy), 32'd1);
    check("bp done", 32'(done), 32'd0);
    check_head("bp head", 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_head($sformatf("stall[%0d]", k), 0);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("bp drain[%0d]", k), k);
      check("bp drain done", 32'(done), 32'd0);
      tick();
    end
    check("bp done end", 32'(done), 32'd1);
    check("bp we end", 32'(mem_we), 32'd0);

    // Full FIFO with push and pop on the same edge
    mem_ready = 1'b0;
    begin_layer(18'd5);
    check("fp overflow cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(i);
      tick();
    end
    drive(4);
    mem_ready = 1'b1;
    tick();
    output_valid = 1'b0;
    check("fp overflow", 32'(overflow), 32'd0);
    check("fp busy", 32'(busy), 32'd1);
    for (int k = 1; k < 5; k++) begin
      check_head($sformatf("fp drain[%0d]", k), k);
      tick();
    end
    check("fp done", 32'(done), 32'd1);
    check("fp we end", 32'(mem_we), 32'd0);

    // Restart in RUN with buffered data and overflow set
    mem_ready = 1'b0;
    begin_layer(18'd10);
    for (int i = 0; i < 5; i++) begin
      drive(i);
      tick();
    end
    output_valid = 1'b0;
    check("rs pre overflow", 32'(overflow), 32'd1);
    check("rs pre busy", 32'(busy), 32'd1);
    check("rs pre done", 32'(done), 32'd0);
    drive(5);
    begin_layer(18'd3);
    output_valid = 1'b0;
    check("rs we", 32'(mem_we), 32'd0);
    check("rs overflow", 32'(overflow), 32'd0);
    check("rs busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i);
      tick();
      check_head($sformatf("rs[%0d]", i), i);
    end
    output_valid = 1'b0;
    tick();
    check("rs done", 32'(done), 32'd1);

    // Zero count, then valid pulses in DONE
    begin_layer(18'd0);
    check("zc busy", 32'(busy), 32'd1);
    check("zc we0", 32'(mem_we), 32'd0);
    tick();
    check("zc we1", 32'(mem_we), 32'd0);
    check("zc done1", 32'(done), 32'd0);
    tick();
    check("zc done2", 32'(done), 32'd1);
    check("zc we2", 32'(mem_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(k);
      tick();
      check("done valid we", 32'(mem_we), 32'd0);
      check("done valid done", 32'(done), 32'd1);
    end
    output_valid = 1'b0;

    // Asynchronous reset while in DRAIN with a stalled entry
    mem_ready = 1'b0;
    begin_layer(18'd1);
    drive(3);
    tick();
    output_valid = 1'b0;
    check("ar busy", 32'(busy), 32'd1);
    check_head("ar head", 3);
    #2;
    arst_n_in = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    arst_n_in = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("post reset busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_output_writer.md
# conv_output_writer

Downstream stage of `top_system`. It consumes the accelerator's unflowcontrolled output stream (`out`, `output_valid`, `output_x`, `output_y`, `output_ch`) and buffers it in a small FIFO. It then writes each result to external memory at a linear address with a valid/ready handshake. It counts accepted results against a programmed total and signals completion once every result has been written back.

## Interface

**Parameters**
- `IO_DATA_WIDTH`, 16, result word width.
- `FEATURE_MAP_WIDTH`, 128, output map width in pixels (x range).
- `FEATURE_MAP_HEIGHT`, 128, output map height (y range).
- `OUTPUT_NB_CHANNELS`, 16, channels per pixel (ch range).
- `FIFO_DEPTH`, 4, buffer entries; must be a power of two and ≥ 2.
- `ADDR_WIDTH`, 18, memory address width; must satisfy 2^ADDR_WIDTH ≥ W·H·C.
- `CNT_WIDTH`, 18, width of the result counter and `expected_count`.

**Ports**
- `clk` — in — 1 — single clock, rising edge.
- `arst_n_in` — in — 1 — reset, asynchronous, active-low.
- `start` — in — 1 — one-cycle pulse that begins a layer.
- `expected_count` — in — CNT_WIDTH — number of results in the layer; sampled on `start`.
- `out` — in — IO_DATA_WIDTH — result data.
- `output_valid` — in — 1 — result present this cycle; there is no backpressure.
- `output_x` — in — $clog2(FEATURE_MAP_WIDTH) — x coordinate.
- `output_y` — in — $clog2(FEATURE_MAP_HEIGHT) — y coordinate.
- `output_ch` — in — $clog2(OUTPUT_NB_CHANNELS) — channel.
- `mem_addr` — out — ADDR_WIDTH — write address.
- `mem_wdata` — out — IO_DATA_WIDTH — write data.
- `mem_we` — out — 1 — write request (valid).
- `mem_ready` — in — 1 — memory accepts the write this cycle.
- `busy` — out — 1 — high in RUN or DRAIN.
- `done` — out — 1 — high in DONE.
- `overflow` — out — 1 — sticky: a result was dropped because the FIFO was full.

## Operation

- **Address formula:** addr = (y·FEATURE_MAP_WIDTH + x)·OUTPUT_NB_CHANNELS + ch.
  - Computed combinationally from the inputs, truncated to ADDR_WIDTH, and stored in the FIFO with the data.
- **FSM: IDLE → RUN → DRAIN → DONE.**
  - **IDLE:** `output_valid` is ignored. `start` loads `expected_count`, clears the accepted counter, flushes the FIFO, clears `overflow`, and moves to RUN.
  - **RUN:** every `output_valid` cycle increments the accepted counter, whether the result is pushed or dropped.
    - When the counter reaches `expected_count`, move to DRAIN; this check covers the increment of that same cycle.
    - If `expected_count` is 0, the FSM passes RUN → DRAIN on the first cycle.
  - **DRAIN:** `output_valid` is ignored. Move to DONE when the FIFO is empty after this cycle's pop.
  - **DONE:** hold until `start`, which behaves exactly as in IDLE.
- **`start` while busy:** aborts the layer and restarts it. The FIFO is flushed, the counters and `overflow` are cleared, and the state becomes RUN. A result arriving in the same cycle is discarded.
- **Push/pop rules:**
  - Push when in RUN, `output_valid` is high, and the FIFO is not full.
  - Pop when `mem_we && mem_ready`.
  - Push and pop in the same cycle are both performed. When the FIFO is full, the simultaneous pop frees the slot, so the push succeeds and no overflow occurs.
  - Push when full with no pop: the result is dropped and `overflow` is set.
- **Memory outputs:**
  - `mem_we` = FIFO not empty.
  - `mem_addr`/`mem_wdata` = head entry, stable while `mem_we && !mem_ready`.
- **Reset (asynchronous, active-low):** state IDLE, FIFO empty, counters 0.
  - Outputs at reset: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `overflow`=0.
  - Reset mid-operation discards all buffered data.

## Timing

- **Latency:** a result valid at rising edge N is pushed at N and appears on `mem_we`/`mem_addr`/`mem_wdata` after edge N, provided the FIFO was empty. No combinational path runs from `output_valid` to `mem_we`.
- **Throughput:** one write per cycle while `mem_ready`=1.
- **State outputs:** `busy`/`done` are registered state decodes. `done` rises the cycle after the last pop.
- **FIFO occupancy:** wrap-around pointers with one extra bit. Full = MSBs differ and the low bits are equal.

## Test plan

- **Streaming, no stall:** `expected_count`=4, `start`. Then 4 consecutive valid results at (x,y,ch) = (0,0,0), (0,0,1), (1,0,0), (127,127,15) with data 0x0011..0x0014.
  - Required: addresses 0, 1, 16, 262143, each one cycle after its input. `done` is asserted 1 cycle after the last write. `overflow`=0.
- **Backpressure fill:** `mem_ready`=0, then 5 results.
  - Required: the first 4 are buffered, the 5th is dropped, `overflow`=1, and the FSM reaches DRAIN.
  - Then raise `mem_ready`: exactly 4 writes in order, then DONE.
- **Full with simultaneous pop:** fill the FIFO to 4 entries, then drive `mem_ready`=1 and a valid result in the same cycle.
  - Required: no drop, `overflow`=0, and all 5 results are written in order.
- **Stalled head stability:** hold `mem_ready`=0 for 3 cycles with `mem_we`=1.
  - Required: `mem_addr`/`mem_wdata` stay unchanged. The first `mem_ready`=1 cycle pops exactly one entry.
- **Restart and reset:**
  - `start` in RUN with 2 entries buffered. Required: FIFO empty next cycle, counter 0, `overflow` cleared.
  - Separately, assert `arst_n_in` low in DRAIN. Required: every output returns to 0 immediately, without waiting for a clock edge.
- **Zero count and non-RUN valid:**
  - `expected_count`=0, then `start`. Required: DONE within 2 cycles with no writes.
  - `output_valid` pulses in IDLE/DONE. Required: no writes and no counter change.
